// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// A single one-bit full-adder slice (two half adders plus an OR) is stepped
// across two WIDTH-bit operands, LSB first, one bit per clock. A start/busy/
// done handshake frames each operation; sum/cout hold the last completed
// result until the next operation finishes.

// Half adder: sum and carry of two single bits.
module serial_add_half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;

endmodule : serial_add_half_adder

// One-bit full-adder slice: HA1 on the operand bits, HA2 folds in the carry,
// and the two partial carries are ORed (they can never both be 1).
module serial_add_fa_slice (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    serial_add_half_adder u_ha1 (
        .i_x (i_a),
        .i_y (i_b),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    serial_add_half_adder u_ha2 (
        .i_x (w_s1),
        .i_y (i_cin),
        .o_s (o_s),
        .o_c (w_c2)
    );

    assign o_cout = w_c1 | w_c2;

endmodule : serial_add_fa_slice

// Controller top: operand/result shift registers, carry flop, bit counter,
// three-state sequencer and registered handshake/result outputs.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_bit_sum;
    logic             w_bit_carry;
    logic [WIDTH-1:0] w_res_next;

    // The shared slice always looks at bit 0 of the operand registers.
    serial_add_fa_slice u_slice (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_bit_sum),
        .o_cout (w_bit_carry)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last     = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    // After WIDTH right shifts the bit entered first (bit 0) lands in the LSB.
    assign w_res_next = {w_bit_sum, r_res_sh[WIDTH-1:1]};

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept only in IDLE, leave RUN after the last bit,
    // DONE lasts exactly one cycle.
    // NOTE: the default assignment before the case keeps every path assigned,
    // so no latch is inferred for w_next_state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load operands on acceptance, then shift one bit per RUN cycle.
    // NOTE: the shift registers are reset as well so an aborted operation
    // leaves no stale operand bits behind; they are flops, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_next;
            r_carry  <= w_bit_carry;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result outputs: updated only on the edge that processes the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_bit_carry;
        end
    end

    // Handshake outputs registered from the next state, so they line up with
    // the state they describe without a combinational path to the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_RUN);
            r_done <= (w_next_state == S_DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_add_ctrl
